// File: rtl/fpas_sequencer.sv
// Sequencer for the half-precision add/sub datapath: debounced buttons drive an
// operand/execute/display FSM. Define FPAS_CHAIN_EN to let B in SHOW chain the result into A.
module fpas_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_btn_n,
  output logic o_pulse
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          w_lvl;
  logic          w_done;

  assign w_lvl   = r_sync[1];
  assign w_done  = (r_cnt == CW'(DEBOUNCE - 1));
  assign o_pulse = r_armed & ~w_lvl & w_done;

  // Armed: count consecutive low cycles; unarmed: count consecutive high cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      if (w_lvl == r_armed) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module fpas_sequencer #(
  parameter int W        = 16,
  parameter int DEBOUNCE = 250000,
  parameter int LAT      = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         LoadA_n,
  input  logic         LoadB_n,
  input  logic         LoadR_n,
  input  logic         OpSel,
  input  logic [W-1:0] KeypadIn,
  input  logic [W-1:0] DpR,
  output logic [W-1:0] DpA,
  output logic [W-1:0] DpB,
  output logic         DpOp,
  output logic [W-1:0] HexOut,
  output logic         ShowResult,
  output logic         Busy,
  output logic         Error
);
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, GOT_A, GOT_B, READY, EXEC, SHOW} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_dpa, w_dpa_nxt;
  logic [W-1:0]  r_dpb, w_dpb_nxt;
  logic [W-1:0]  r_res, w_res_nxt;
  logic          r_op, w_op_nxt;
  logic          r_err, w_err_nxt;
  logic [LW-1:0] r_settle, w_settle_nxt;
  logic [2:0]    w_btn_n;
  logic [2:0]    w_pulse;
  logic          w_pa, w_pb, w_pr;

  assign w_btn_n = {LoadR_n, LoadB_n, LoadA_n};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    fpas_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .Clock   (Clock),
      .Reset   (Reset),
      .i_btn_n (w_btn_n[g]),
      .o_pulse (w_pulse[g])
    );
  end

  // Same-cycle pulses resolve A > B > R; losers are dropped.
  assign w_pa = w_pulse[0];
  assign w_pb = w_pulse[1] & ~w_pulse[0];
  assign w_pr = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_dpa    <= '0;
      r_dpb    <= '0;
      r_res    <= '0;
      r_op     <= 1'b0;
      r_err    <= 1'b0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dpa    <= w_dpa_nxt;
      r_dpb    <= w_dpb_nxt;
      r_res    <= w_res_nxt;
      r_op     <= w_op_nxt;
      r_err    <= w_err_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dpa_nxt    = r_dpa;
    w_dpb_nxt    = r_dpb;
    w_res_nxt    = r_res;
    w_op_nxt     = r_op;
    w_err_nxt    = 1'b0;
    w_settle_nxt = r_settle;
    case (r_state)
      IDLE: begin
        if (w_pa) begin
          w_dpa_nxt   = KeypadIn;
          w_state_nxt = GOT_A;
        end else if (w_pb) begin
          w_dpb_nxt   = KeypadIn;
          w_state_nxt = GOT_B;
        end else if (w_pr) begin
          w_err_nxt = 1'b1;
        end
      end
      GOT_A: begin
        if (w_pa) begin
          w_dpa_nxt = KeypadIn;
        end else if (w_pb) begin
          w_dpb_nxt   = KeypadIn;
          w_state_nxt = READY;
        end else if (w_pr) begin
          w_err_nxt = 1'b1;
        end
      end
      GOT_B: begin
        if (w_pa) begin
          w_dpa_nxt   = KeypadIn;
          w_state_nxt = READY;
        end else if (w_pb) begin
          w_dpb_nxt = KeypadIn;
        end else if (w_pr) begin
          w_err_nxt = 1'b1;
        end
      end
      READY: begin
        if (w_pa) begin
          w_dpa_nxt = KeypadIn;
        end else if (w_pb) begin
          w_dpb_nxt = KeypadIn;
        end else if (w_pr) begin
          w_op_nxt     = OpSel;
          w_settle_nxt = '0;
          w_state_nxt  = EXEC;
        end
      end
      EXEC: begin
        // Operands and op are frozen here; the datapath has LAT cycles to settle.
        if (r_settle == LW'(LAT - 1)) begin
          w_res_nxt   = DpR;
          w_state_nxt = SHOW;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      SHOW: begin
        if (w_pa) begin
          w_dpa_nxt   = KeypadIn;
          w_state_nxt = GOT_A;
        end else if (w_pb) begin
`ifdef FPAS_CHAIN_EN
          w_dpa_nxt   = r_res;
          w_dpb_nxt   = KeypadIn;
          w_state_nxt = READY;
`endif
        end else if (w_pr) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign DpA        = r_dpa;
  assign DpB        = r_dpb;
  assign DpOp       = r_op;
  assign ShowResult = (r_state == SHOW);
  assign Busy       = (r_state == EXEC);
  assign Error      = r_err;
  assign HexOut     = ShowResult ? r_res : KeypadIn;
endmodule

// File: tb/tb_fpas_sequencer.sv
// Randomized self-checking bench for fpas_sequencer against a press-level
// reference model; the datapath is modelled with real arithmetic on half floats.
module tb_fpas_sequencer;
  localparam int W = 16, DEB = 4, LAT = 2;
  localparam int S_IDLE = 0, S_GOT_A = 1, S_GOT_B = 2, S_READY = 3, S_SHOW = 5;

  logic         gclk = 1'b0;
  logic         grst_n;
  logic         a_n, b_n, r_n, op_sel;
  logic [W-1:0] key, dpr, dpa, dpb, hex;
  logic         dpop, show, busy, err;

  int checks = 0, failures = 0, err_seen = 0;
  int m_st;
  logic [W-1:0] m_a, m_b, m_res;
  logic m_op;

  always #5 gclk = ~gclk;

  fpas_sequencer #(.W(W), .DEBOUNCE(DEB), .LAT(LAT)) dut (
    .Clock(gclk), .Reset(grst_n), .LoadA_n(a_n), .LoadB_n(b_n), .LoadR_n(r_n),
    .OpSel(op_sel), .KeypadIn(key), .DpR(dpr), .DpA(dpa), .DpB(dpb), .DpOp(dpop),
    .HexOut(hex), .ShowResult(show), .Busy(busy), .Error(err)
  );

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) / 16777216.0;
    else        m = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real m;
    int  e, f;
    logic [15:0] h;
    if (r == 0.0) return 16'h0000;
    m = (r < 0.0) ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = int'((m - 1.0) * 1024.0);
    h = {(r < 0.0), e[4:0], f[9:0]};
    return h;
  endfunction

  function automatic logic [15:0] fp(input logic [15:0] x, input logic [15:0] y, input logic sub);
    return r2h(sub ? h2r(x) - h2r(y) : h2r(x) + h2r(y));
  endfunction

  // Behavioural datapath feeding the DUT.
  assign dpr = fp(dpa, dpb, dpop);

  always @(negedge gclk) if (err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_a = '0; m_b = '0; m_res = '0; m_op = 1'b0;
  endtask

  // Applies one resolved pulse (A > B > R) using the sequencing rules.
  task automatic model_step(input int mask, input logic [15:0] k, input logic op,
                            output bit exp_err, output bit exp_exec);
    exp_err = 0; exp_exec = 0;
    if (mask[0]) begin
      m_a = k;
      if (m_st == S_GOT_B || m_st == S_READY) m_st = S_READY;
      else m_st = S_GOT_A;
    end else if (mask[1]) begin
      if (m_st == S_SHOW) begin
`ifdef FPAS_CHAIN_EN
        m_a = m_res; m_b = k; m_st = S_READY;
`endif
      end else begin
        m_b = k;
        if (m_st == S_IDLE) m_st = S_GOT_B;
        else if (m_st == S_GOT_A) m_st = S_READY;
      end
    end else if (mask[2]) begin
      if (m_st == S_READY) begin
        m_op = op; m_res = fp(m_a, m_b, op); m_st = S_SHOW; exp_exec = 1;
      end else begin
        exp_err = 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".dpa"}, 32'(dpa), 32'(m_a));
    chk({tag, ".dpb"}, 32'(dpb), 32'(m_b));
    chk({tag, ".dpop"}, 32'(dpop), 32'(m_op));
    chk({tag, ".show"}, 32'(show), 32'(m_st == S_SHOW));
    chk({tag, ".hex"}, 32'(hex), 32'((m_st == S_SHOW) ? m_res : key));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Holds the masked buttons low for `hold` cycles, then waits for re-arm.
  task automatic press(input string tag, input int mask, input int hold, input bit pulses);
    logic [15:0] k0;
    logic op0;
    int e0, busy_n;
    bit prev_busy, show_after, ee, ex;
    k0 = key; op0 = op_sel; e0 = err_seen; busy_n = 0; prev_busy = 0; show_after = 0;
    @(negedge gclk);
    a_n = ~mask[0]; b_n = ~mask[1]; r_n = ~mask[2];
    for (int i = 0; i < hold + DEB + 10; i++) begin
      @(negedge gclk);
      if (i == hold - 1) begin a_n = 1; b_n = 1; r_n = 1; end
      if (i == 50) key = k0 ^ 16'h0400;
      if (prev_busy && !busy) show_after = show;
      if (busy) begin busy_n++; op_sel = ~op_sel; end
      prev_busy = busy;
    end
    if (pulses) model_step(mask, k0, op0, ee, ex);
    else begin ee = 0; ex = 0; end
    chk({tag, ".err"}, 32'(err_seen - e0), 32'(ee));
    chk({tag, ".busyn"}, 32'(busy_n), ex ? 32'(LAT) : 32'd0);
    if (ex) chk({tag, ".showafter"}, 32'(show_after), 32'd1);
    check_state(tag);
  endtask

  initial begin
    bit ready_seen;
    int mask;
    grst_n = 0; a_n = 1; b_n = 1; r_n = 1; op_sel = 0; key = 16'h1234;
    model_reset();
    repeat (3) @(negedge gclk);
    check_state("reset");
    grst_n = 1;
    repeat (DEB + 4) @(negedge gclk);

    // Directed: 1.0 + 2.0, then 1.0 - 2.0.
    key = 16'h3C00; press("a1", 1, 8, 1);
    key = 16'h4000; press("b1", 2, 8, 1);
    op_sel = 0;     press("r_add", 4, 8, 1);
    chk("hex_4200", 32'(hex), 32'h4200);
    key = 16'h3C00; press("a2", 1, 8, 1);
    key = 16'h4000; press("b2", 2, 8, 1);
    op_sel = 1;     press("r_sub", 4, 8, 1);
    chk("hex_bc00", 32'(hex), 32'hBC00);
    chk("dpop_1", 32'(dpop), 32'd1);

    // Rejected R in IDLE and GOT_A; glitch, long hold, simultaneous A+B.
    grst_n = 0; model_reset(); @(negedge gclk); grst_n = 1;
    repeat (DEB + 4) @(negedge gclk);
    press("r_idle", 4, 8, 1);
    key = 16'h4400; press("glitch", 1, 2, 0);
    press("hold100", 1, 100, 1);
    press("r_gota", 4, 8, 1);
    key = 16'h4500; press("ab_same", 3, 8, 1);

    // Reset during the first EXEC cycle: nothing is captured afterwards.
    key = 16'h4000; press("b3", 2, 8, 1);
    @(negedge gclk); r_n = 0;
    ready_seen = 0;
    for (int i = 0; i < 40 && !ready_seen; i++) begin
      @(negedge gclk);
      if (busy) ready_seen = 1;
    end
    chk("exec_reached", 32'(ready_seen), 32'd1);
    grst_n = 0; #1;
    model_reset();
    chk("rst_exec.busy", 32'(busy), 32'd0);
    chk("rst_exec.dpa", 32'(dpa), 32'd0);
    chk("rst_exec.dpb", 32'(dpb), 32'd0);
    chk("rst_exec.show", 32'(show), 32'd0);
    repeat (2) @(negedge gclk); grst_n = 1;
    repeat (8) @(negedge gclk); r_n = 1;
    repeat (DEB + 6) @(negedge gclk);
    check_state("post_rst");
    press("r_after_rst", 4, 8, 1);

    // SHOW then B: chains in the optional build, ignored otherwise.
    key = 16'h3C00; press("a4", 1, 8, 1);
    key = 16'h4000; press("b4", 2, 8, 1);
    op_sel = 0;     press("r4", 4, 8, 1);
    key = 16'h3C00; press("b_show", 2, 8, 1);
    op_sel = 0;     press("r_chain", 4, 8, 1);
`ifdef FPAS_CHAIN_EN
    chk("chain_hex", 32'(hex), 32'h4400);
`else
    chk("nochain_hex", 32'(hex), 32'h4200);
`endif

    // Randomized press sequence with small integer operands (exact in half).
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 6))
        0, 1:    mask = 1;
        2, 3:    mask = 2;
        4, 5:    mask = 4;
        default: mask = 3;
      endcase
      key = r2h(real'($urandom_range(1, 200)));
      op_sel = 1'($urandom_range(0, 1));
      press($sformatf("rnd%0d", n), mask, 8, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/fpas_sequencer.md
# fpas_sequencer

- Synchronous controller that sequences the half-precision FP adder/subtractor datapath.
- Replaces asynchronous button-edge register loading with debounced, clock-domain press detection and an operand/execute/display state machine.
- Owns the A/B operand registers, the operation bit and the result register.
- Sits between the keypad capture block, the FP datapath and the multiplexed 7-segment display.

## Interface
Parameters:
- W, 16, operand/result width
- DEBOUNCE, 250000, stable-level cycles required to accept a button press or release (≥2)
- LAT, 2, cycles allowed for datapath settle before result capture (≥1)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  reset, asynchronous, active-low
- LoadA_n  in  1  raw push button, active-low, asynchronous to Clock
- LoadB_n  in  1  raw push button, active-low
- LoadR_n  in  1  raw push button, active-low
- OpSel  in  1  0 = add, 1 = subtract (A−B)
- KeypadIn  in  W  current keypad value
- DpR  in  W  datapath result
- DpA  out  W  operand A register
- DpB  out  W  operand B register
- DpOp  out  1  latched operation
- HexOut  out  W  display value: ResultReg when ShowResult=1, else KeypadIn
- ShowResult  out  1  result display select
- Busy  out  1  high in EXEC
- Error  out  1  one-cycle pulse on a rejected LoadR press

## Operation
- Each button: 2-flop synchronizer, then a debounce counter. A press pulse (one cycle) fires when the synchronized level has been low for DEBOUNCE consecutive cycles. The button re-arms only after being high for DEBOUNCE consecutive cycles. A held button produces exactly one pulse.
- Simultaneous pulses in one cycle: priority A > B > R. Lower-priority pulses in that cycle are dropped, not queued.
- States: IDLE, GOT_A, GOT_B, READY, EXEC, SHOW.
  - IDLE: A→load DpA, GOT_A; B→load DpB, GOT_B; R→Error.
  - GOT_A: A→reload DpA, stay; B→load DpB, READY; R→Error.
  - GOT_B: B→reload DpB, stay; A→load DpA, READY; R→Error.
  - READY: A or B→reload that operand, stay; R→latch DpOp←OpSel, clear settle counter, EXEC.
  - EXEC: all presses ignored, no Error. After LAT cycles, ResultReg←DpR, SHOW.
  - SHOW: A→load DpA, ShowResult←0, GOT_A (B treated as invalid); R→Error; B→see Configuration.
- Loads always capture KeypadIn in the cycle of the pulse.
- Reset low (any state, including mid-EXEC) → IDLE, settle counter cleared, debounce state cleared, all buttons unarmed until seen high for DEBOUNCE cycles.

## Timing
- Reset values: DpA=0, DpB=0, DpOp=0, ResultReg=0, ShowResult=0, Busy=0, Error=0, HexOut=KeypadIn.
- Press latency: first raw-low cycle → pulse after 2 sync cycles + DEBOUNCE cycles. Operand register updates on the edge ending the pulse cycle.
- R pulse in READY at cycle t:
  - Busy=1 during t+1 … t+LAT.
  - ResultReg captured on the edge ending t+LAT.
  - ShowResult=1 and Busy=0 from t+LAT+1.
- Error is asserted during the cycle after the rejected pulse, for exactly one cycle.
- DpA, DpB and DpOp are stable throughout EXEC.
- HexOut is combinational from ShowResult, ResultReg and KeypadIn.

## Configuration
- FPAS_CHAIN_EN defined:
  - A B pulse in SHOW sets DpA←ResultReg and DpB←KeypadIn, clears ShowResult and goes to READY. This allows chained operations.
- FPAS_CHAIN_EN undefined:
  - A B pulse in SHOW is ignored, with no Error, and the state remains SHOW.

## Test plan
- DEBOUNCE=4, LAT=2. KeypadIn=3C00, press A; KeypadIn=4000, press B; OpSel=0, press R; bench DpR=A+B model → DpA=3C00, DpB=4000, Busy high 2 cycles, then ShowResult=1, HexOut=4200.
- Same operands, OpSel=1 → DpOp=1, HexOut=BC00. OpSel toggled during EXEC → DpOp unchanged.
- R pressed in IDLE and in GOT_A → one Error pulse each, state unchanged, ShowResult=0.
- 2-cycle low glitch on LoadA_n → no load. A held low 100 cycles → exactly one load. A and B pulses in the same cycle → only DpA loaded.
- Reset asserted during EXEC cycle 1 → immediately IDLE, DpA=DpB=0, Busy=0, ShowResult=0, no later result capture.
- After result 4200 in SHOW, KeypadIn=3C00, press B. With FPAS_CHAIN_EN: DpA=4200, DpB=3C00, READY; R (OpSel=0) → HexOut=4400. Without FPAS_CHAIN_EN: state stays SHOW, HexOut=4200.
